// File: rtl/regset_pkg.sv
// Shared types and entry helpers for the parametrised register set.
// An entry is {parity, grubby, data}. Helpers work on a widest-case
// container so they can serve any DATA_W up to MAX_DW.
package regset_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int MAX_DW = 64;
  localparam int MAX_EW = MAX_DW + 2;

  typedef logic [MAX_DW-1:0] wide_data_t;
  typedef logic [MAX_EW-1:0] wide_entry_t;

  // Even parity: XOR of all data bits (zero padding does not change it).
  function automatic logic parity(input wide_data_t d);
    return ^d;
  endfunction

  // Place data in the low dw bits, grubby at bit dw, parity at bit dw+1.
  function automatic wide_entry_t entry_pack(input wide_data_t d, input logic g,
                                             input logic p, input int unsigned dw);
    return wide_entry_t'(d) | (wide_entry_t'(g) << dw) | (wide_entry_t'(p) << (dw + 1));
  endfunction

  function automatic wide_data_t entry_data(input wide_entry_t e, input int unsigned dw);
    wide_entry_t mask;
    mask = (wide_entry_t'(1) << dw) - wide_entry_t'(1);
    return wide_data_t'(e & mask);
  endfunction

  function automatic logic entry_grubby(input wide_entry_t e, input int unsigned dw);
    return ((e >> dw) & wide_entry_t'(1)) != '0;
  endfunction

  function automatic logic entry_parity(input wide_entry_t e, input int unsigned dw);
    return ((e >> (dw + 1)) & wide_entry_t'(1)) != '0;
  endfunction

endpackage

// File: rtl/regset_bank.sv
// One-write / one-read synchronous RAM, read-first, registered output.
// Written without reset so it maps onto block RAM.
module regset_bank #(
  parameter int WIDTH  = 34,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rd
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port and registered read-first read port.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/regset_param.sv
// Parametrised register set: NREGS entries of {parity, grubby, data},
// NRD registered read ports, register 0 reads as zero, a clear engine
// that sweeps the array after reset, and parity error reporting.
module regset_param
  import regset_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int ECNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic                  wg,
  input  logic                  winj,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rg,
  output logic                  ready,
  output logic                  perr,
  output logic [ECNT_W-1:0]     err_count
);

  localparam int NREGS = 2**ADDR_W;
  localparam int EW    = DATA_W + 2;

  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(NREGS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ECNT_W-1:0] ECNT_ONE = ECNT_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              clr_we;
  logic              usr_we;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_wa;
  logic [EW-1:0]     bank_wd;
  logic [EW-1:0]     wr_entry;
  logic [NRD-1:0]    mis_vec;

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear engine next state: sweep every entry once, then run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready = (state == RUN);

  // User writes need a usable array and never touch register 0.
  assign usr_we   = we && ready && (wa != '0);
  assign wr_entry = EW'(entry_pack(wide_data_t'(wd), wg,
                                   parity(wide_data_t'(wd)) ^ winj, DATA_W));

  // Nothing reaches the array on a reset edge, even if the engine was running.
  assign bank_we = !reset && (clr_we || usr_we);
  assign bank_wa = clr_we ? cnt[ADDR_W-1:0] : wa;
  assign bank_wd = clr_we ? '0 : wr_entry;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [ADDR_W-1:0] ra_p;
    logic              hit;
    logic [EW-1:0]     q_p1;
    wide_entry_t       q_wide;
    logic [DATA_W-1:0] q_dat;
    logic              q_grb;
    logic              q_mis;
    logic              vld_p1;
    logic              byp_p1;
    logic [DATA_W-1:0] byd_p1;
    logic              byg_p1;

    assign ra_p = ra[p*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && usr_we && (wa == ra_p);

    regset_bank #(
      .WIDTH  (EW),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk (clk),
      .we  (bank_we),
      .wa  (bank_wa),
      .wd  (bank_wd),
      .ra  (ra_p),
      .rd  (q_p1)
    );

    // ---- stage p0 -> p1: read qualifiers travel with the RAM read ----
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1 <= 1'b0;
        byp_p1 <= 1'b0;
      end else begin
        vld_p1 <= ready && (ra_p != '0) && !hit;
        byp_p1 <= hit;
      end
    end

    // Same-cycle write data captured for the bypass path.
    always_ff @(posedge clk) begin
      byd_p1 <= wd;
      byg_p1 <= wg;
    end

    // ---- stage p1: unpack, parity check and output masking ----
    assign q_wide = wide_entry_t'(q_p1);
    assign q_dat  = DATA_W'(entry_data(q_wide, DATA_W));
    assign q_grb  = entry_grubby(q_wide, DATA_W);
    assign q_mis  = vld_p1 &&
                    (parity(entry_data(q_wide, DATA_W)) != entry_parity(q_wide, DATA_W));

    assign rd[p*DATA_W +: DATA_W] = byp_p1 ? byd_p1 : (vld_p1 ? q_dat : '0);
    assign rg[p]                  = byp_p1 ? byg_p1 : (vld_p1 && (q_grb || q_mis));
    assign mis_vec[p]             = q_mis;
  end

  assign perr = |mis_vec;

  // Saturating count of cycles with a parity error on any port.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (perr && (err_count != '1)) begin
      err_count <= err_count + ECNT_ONE;
    end
  end

endmodule

// File: tb/tb_regset_param.sv
// Bench for regset_param: one instance with bypass, one read-first,
// both driven by the same stimulus and checked against a reference model.
module tb_regset_param;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NRD   = 2;
  localparam int NREGS = 64;
  localparam int EW    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [AW-1:0]     wa = '0;
  logic [DW-1:0]     wd = '0;
  logic              wg = 1'b0;
  logic              winj = 1'b0;
  logic [NRD*AW-1:0] ra = '0;

  logic [NRD*DW-1:0] rd_b1, rd_b0;
  logic [NRD-1:0]    rg_b1, rg_b0;
  logic              ready_b1, ready_b0, perr_b1, perr_b0;
  logic [EW-1:0]     ec_b1, ec_b0;

  regset_param #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .BYPASS(1), .ECNT_W(EW)) u_b1 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wg(wg), .winj(winj), .ra(ra),
    .rd(rd_b1), .rg(rg_b1), .ready(ready_b1), .perr(perr_b1), .err_count(ec_b1));

  regset_param #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .BYPASS(0), .ECNT_W(EW)) u_b0 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wg(wg), .winj(winj), .ra(ra),
    .rd(rd_b0), .rg(rg_b0), .ready(ready_b0), .perr(perr_b0), .err_count(ec_b0));

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: architectural array contents plus expected outputs.
  logic [DW-1:0] m_d [NREGS];
  bit            m_g [NREGS];
  bit            m_p [NREGS];
  int            since = 0;
  logic [DW-1:0] e_rd [2][NRD];
  bit            e_rg [2][NRD];
  bit            e_perr [2];
  int            e_cnt [2];
  bit            e_ready = 1'b0;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_d[i] = '0; m_g[i] = 1'b0; m_p[i] = 1'b0;
    end
    for (int v = 0; v < 2; v++) begin
      e_perr[v] = 1'b0; e_cnt[v] = 0;
      for (int p = 0; p < NRD; p++) begin e_rd[v][p] = '0; e_rg[v][p] = 1'b0; end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model update for one rising edge; v=1 is the bypassing instance.
  task automatic model_edge();
    bit rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit mis;
    rdy = (since >= NREGS);
    if (reset) begin
      since   = 0;
      e_ready = 1'b0;
      for (int v = 0; v < 2; v++) begin
        e_perr[v] = 1'b0; e_cnt[v] = 0;
        for (int p = 0; p < NRD; p++) begin e_rd[v][p] = '0; e_rg[v][p] = 1'b0; end
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (e_perr[v] && e_cnt[v] < (2**EW - 1)) e_cnt[v] = e_cnt[v] + 1;
        e_perr[v] = 1'b0;
        for (int p = 0; p < NRD; p++) begin
          a = ra[p*AW +: AW];
          if (!rdy || a == 0) begin
            e_rd[v][p] = '0; e_rg[v][p] = 1'b0;
          end else if (v == 1 && we && wa == a) begin
            e_rd[v][p] = wd; e_rg[v][p] = wg;
          end else begin
            d   = m_d[a];
            mis = ((^d) != m_p[a]);
            e_rd[v][p] = d;
            e_rg[v][p] = m_g[a] | mis;
            if (mis) e_perr[v] = 1'b1;
          end
        end
      end
      if (rdy && we && wa != 0) begin
        m_d[wa] = wd; m_g[wa] = wg; m_p[wa] = (^wd) ^ winj;
      end
      if (since < NREGS) begin
        m_d[since] = '0; m_g[since] = 1'b0; m_p[since] = 1'b0;
        since++;
      end
      e_ready = (since >= NREGS);
    end
  endtask

  task automatic compare_all();
    logic [NRD*DW-1:0] rdv;
    logic [NRD-1:0]    rgv;
    for (int v = 0; v < 2; v++) begin
      rdv = v ? rd_b1 : rd_b0;
      rgv = v ? rg_b1 : rg_b0;
      chk($sformatf("cyc%0d_v%0d_ready", cyc, v), v ? ready_b1 : ready_b0, e_ready);
      chk($sformatf("cyc%0d_v%0d_perr", cyc, v), v ? perr_b1 : perr_b0, e_perr[v]);
      chk($sformatf("cyc%0d_v%0d_err_count", cyc, v), v ? ec_b1 : ec_b0, 64'(e_cnt[v]));
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("cyc%0d_v%0d_rd%0d", cyc, v, p), rdv[p*DW +: DW], e_rd[v][p]);
        chk($sformatf("cyc%0d_v%0d_rg%0d", cyc, v, p), rgv[p], e_rg[v][p]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          wg;
    logic          winj;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_rg;
    logic          e_perr;
    logic [DW-1:0] e_rd0_nb;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    tbl[0] = '{1'b1, 6'd7, 32'h12345678, 1'b1, 1'b0, 6'd0, 6'd0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd7, 6'd7, 32'h12345678, 32'h12345678, 2'b11, 1'b0, 32'h12345678};
    tbl[2] = '{1'b1, 6'd9, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd9, 6'd7, 32'hA5A5A5A5, 32'h12345678, 2'b10, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 6'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 6'd0, 6'd9, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 6'd3, 32'h00000001, 1'b0, 1'b1, 6'd3, 6'd0, 32'h1,        32'h0,        2'b00, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd3, 6'd3, 32'h1,        32'h1,        2'b11, 1'b1, 32'h1};
    tbl[6] = '{1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 6'd5, 6'd3, 32'h0,        32'h1,        2'b10, 1'b1, 32'h0};

    // Reset for 3 cycles, then measure the clear duration.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_ready", ready_b1, 1'b0);
    chk("reset_rd", rd_b1, '0);
    reset = 1'b0;
    n = 0;
    while (ready_b1 !== 1'b1 && n < 200) begin step(); n++; end
    chk("ready_latency", n, 64);

    // Reset pulse 30 cycles into a clear; dropped writes to x5 while not ready.
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 30; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    n = 0;
    wa = 6'd5; wd = 32'hDEADBEEF;
    while (ready_b1 !== 1'b1 && n < 200) begin
      we = (n < 20);
      step();
      n++;
    end
    we = 1'b0;
    chk("ready_latency_restart", n, 64);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; wg = tbl[i].wg; winj = tbl[i].winj;
      ra = {tbl[i].ra1, tbl[i].ra0};
      step();
      chk($sformatf("vec%0d_rd0", i), rd_b1[DW-1:0], tbl[i].e_rd0);
      chk($sformatf("vec%0d_rd1", i), rd_b1[2*DW-1:DW], tbl[i].e_rd1);
      chk($sformatf("vec%0d_rg", i), rg_b1, tbl[i].e_rg);
      chk($sformatf("vec%0d_perr", i), perr_b1, tbl[i].e_perr);
      chk($sformatf("vec%0d_rd0_readfirst", i), rd_b0[DW-1:0], tbl[i].e_rd0_nb);
    end
    winj = 1'b0; we = 1'b0;
    chk("err_count_first", ec_b1, 8'd1);

    // Repeated bad-parity reads drive the counter into saturation.
    ra = {6'd3, 6'd3};
    for (int i = 0; i < 300; i++) step();
    chk("err_count_sat", ec_b1, 8'hFF);
    chk("err_count_sat_readfirst", ec_b0, 8'hFF);
    chk("perr_still_high", perr_b1, 1'b1);

    // Randomized traffic with occasional resets.
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 699) == 0);
      we    = 1'($urandom_range(0, 1));
      wa    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 15));
      wd    = $urandom();
      wg    = 1'($urandom_range(0, 1));
      winj  = ($urandom_range(0, 7) == 0);
      ra    = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      step();
    end
    reset = 1'b0; we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regset_param.md
# regset_param

Parametrised successor to the fixed 32-bit, two-read-port register set. Holds `NREGS` entries of `DATA_W` data bits plus a stored grubby bit and a real even-parity bit, with `NRD` registered read ports. Register 0 is hard-wired to zero. A sequential clear engine zeroes the whole array after reset, so no simulator preinit is needed. Sits beside `Pipeline` and replaces the fixed register-set instance, with parity errors reported and counted.

## Interface
- `DATA_W`, 32: data width per entry.
- `ADDR_W`, 6: address width; `NREGS` = 2**`ADDR_W`.
- `NRD`, 2: number of read ports, at least 1.
- `BYPASS`, 1: 1 returns same-cycle write data on an address match; 0 returns the old contents (read-first).
- `ECNT_W`, 8: width of the parity error counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  write enable.
- `wa`  in  `ADDR_W`  write address.
- `wd`  in  `DATA_W`  write data.
- `wg`  in  1  grubby bit stored with the write.
- `winj`  in  1  verification hook: store the inverted parity bit with this write.
- `ra`  in  `NRD*ADDR_W`  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- `rd`  out  `NRD*DATA_W`  registered read data, packed the same way as `ra`.
- `rg`  out  `NRD`  registered grubby flag per port.
- `ready`  out  1  high when the clear is complete and the array is usable.
- `perr`  out  1  one-cycle pulse, aligned with `rd`, when any port read a parity mismatch.
- `err_count`  out  `ECNT_W`  saturating count of cycles in which `perr` was high.

## Operation
- **Entry format:** {parity, grubby, data}; parity is the XOR of the data bits.
- **Write:** when `we` && `ready` && `wa`!=0, the entry takes {^`wd` ^ `winj`, `wg`, `wd`}.
  - Writes to address 0 are dropped.
  - Writes while not `ready` are dropped.
- **Read, port p:**
  - `rd[p]` <= stored data; `rg[p]` <= stored grubby | mismatch.
  - mismatch = (^data != parity).
- **Read of address 0:** `rd`=0 and `rg`=0, independent of array contents.
- **Read while not `ready`:** `rd`=0, `rg`=0, `perr`=0.
- **Bypass** (`BYPASS`=1): when `we` && `ready` && `wa`==`ra[p]` && `wa`!=0:
  - `rd[p]` <= `wd`, `rg[p]` <= `wg`.
  - No mismatch is evaluated for that port, even if `winj`=1.
- **`perr`:** <= OR of the mismatch terms over all ports. `err_count` increments when `perr` is set and holds at all-ones.
- **Clear FSM**, states CLEAR and RUN, with counter `cnt` of `ADDR_W`+1 bits:
  - `reset`: state <= CLEAR, `cnt` <= 0, no array write.
  - CLEAR: write {0,0,0} to entry `cnt`, then `cnt`++. When `cnt`==NREGS-1, state <= RUN on the same edge.
  - RUN: stays in RUN until `reset`.
  - `ready` = (state==RUN), registered.
- **Reset mid-clear:** the clear restarts at entry 0. Entries already cleared are cleared again.

## Timing
- **Reset values:** `rd`=0, `rg`=0, `ready`=0, `perr`=0, `err_count`=0, state CLEAR.
- **Clear duration:** the first edge with `reset` low clears entry 0. `ready` rises after edge NREGS (64 for the defaults). The total is NREGS cycles from reset release.
- **Read latency:** 1 cycle. An address on `ra` at edge n gives `rd`/`rg`/`perr` after edge n.
- **Write latency:** a write at edge n is visible to a non-bypassed read issued at edge n+1.
- **Same-cycle write and read, same address:** new data when `BYPASS`=1, old data when `BYPASS`=0.
- **Multiple ports, same address:** every port returns identical data in the same cycle.
- **`err_count` latency:** updates one cycle after `perr`.

## Structure
- Package `regset_pkg` holds:
  - the state enum {CLEAR, RUN};
  - the entry-pack and entry-unpack helpers;
  - the parity function.
- Sub-module `regset_bank` is a 1-write/1-read synchronous RAM of width `DATA_W`+2 and depth NREGS.
  - It is instantiated `NRD` times, all with the same write.
  - It maps onto BRAM.
- The top level owns the clear FSM, the write mux (clear vs. user), bypass, address-0 masking and error counting.

## Test plan
- Reset for 3 cycles, then release → `ready` low for exactly 64 cycles and high after edge 64. Pulse `reset` at cycle 30 → `ready` rises 64 cycles after the second release.
- Before `ready`, write x5=0xDEADBEEF; after `ready`, read x5 → `rd`=0 (write dropped). Write x0=0xFFFFFFFF, read x0 → 0.
- After `ready`, write x7=0x12345678 with `wg`=1; next cycle read x7 on both ports → `rd`=0x12345678, `rg`=2'b11, `perr`=0.
- Same cycle: write x9=0xA5A5A5A5 and read x9 → `BYPASS`=1 gives 0xA5A5A5A5; `BYPASS`=0 gives the previous value 0.
- Write x3=0x1 with `winj`=1, then read x3 → `rg`=1, `perr` pulses for 1 cycle, `err_count`=1. Repeat 300 reads with `ECNT_W`=8 → `err_count` saturates at 255.
